nn_job_scheduler: RTL and testbench
===================================

Name: nn_job_scheduler

Overview:
- Shares one dataflow/compute pipeline between NUM_REQ independent job requesters, e.g. per-layer DMA engines or host queues.
- Arbitrates round-robin and writes the winner's configuration word over the controller's config interface.
- Pulses start_process, then waits for process_done and reports completion or timeout back to the originating requester.
- Sits directly upstream of the dataflow controller, driving its cfg_write/cfg_wdata and start_process inputs.

Parameters:
NUM_REQ, 4, number of requesters (2..16)
DATA_WIDTH, 32, width of a job configuration word
TIMEOUT_CYCLES, 1024, max cycles allowed in CFG or WAIT before the job is aborted (>=4)
CNT_WIDTH, 16, width of completed-job counter

Ports:
clk  in  1  clock
reset  in  1  reset, asynchronous, active-high
req  in  NUM_REQ  per-requester job request level; held until ack
req_cfg  in  NUM_REQ*DATA_WIDTH  per-requester config word; slice i = bits [i*DATA_WIDTH +: DATA_WIDTH]
ack  out  NUM_REQ  one-hot, 1-cycle pulse: job accepted
done  out  NUM_REQ  one-hot, 1-cycle pulse: job completed
err  out  NUM_REQ  one-hot, 1-cycle pulse: job timed out
cfg_write  out  1  config write strobe to controller
cfg_wdata  out  DATA_WIDTH  config word to controller
cfg_ready  in  1  controller config acknowledge
start_process  out  1  1-cycle start pulse to controller
process_done  in  1  controller completion (latched level, cleared by start)
abort  out  1  1-cycle pulse on timeout, for downstream flush
busy  out  1  high whenever state != IDLE
grant_id  out  $clog2(NUM_REQ)  index of current or last granted requester
job_count  out  CNT_WIDTH  completed jobs, wraps at 2^CNT_WIDTH

Behaviour:
- All outputs are registered. On reset, every output is 0, state = IDLE, timer = 0, and last_grant = NUM_REQ-1, so req[0] has first priority.
- Reset mid-job: immediate return to IDLE. No done, err or abort pulse is generated.
- States: IDLE, CFG, START, WAIT.
- IDLE:
  - req is sampled only in IDLE.
  - If any req bit is set, the winner is the first set bit searching from last_grant+1 upward, wrapping modulo NUM_REQ.
  - At that edge: state<=CFG, ack[winner]<=1, grant_id<=winner, cfg_wdata<=req_cfg slice of winner, cfg_write<=1, timer<=0.
  - Latency is req high -> ack and cfg_write high on the next cycle. With no req, the block stays in IDLE.
- CFG:
  - ack drops after 1 cycle. cfg_write and cfg_wdata are held stable until cfg_ready is sampled high.
  - Then: cfg_write<=0, start_process<=1, state<=START.
- START: start_process<=0, timer<=0, state<=WAIT. start_process is high exactly 1 cycle.
- WAIT:
  - process_done is ignored in the first WAIT cycle, to clear any stale latch from the previous job. It is sampled from the second cycle onward.
  - On process_done=1: done[grant_id]<=1, job_count<=job_count+1 (wrapping), last_grant<=grant_id, state<=IDLE.
- Timeout:
  - timer increments every cycle in CFG and WAIT and saturates.
  - When timer reaches TIMEOUT_CYCLES-1 without the exit condition, the next edge sets err[grant_id]<=1, abort<=1, cfg_write<=0, last_grant<=grant_id, state<=IDLE.
  - job_count is not incremented on timeout.
- Simultaneous process_done and timeout in the same cycle: done wins; no err, no abort.
- A requester dropping req after ack does not cancel its job. A requester re-asserting req immediately is re-arbitrated fairly, after the other pending requesters.
- Back-to-back jobs: minimum 1 IDLE cycle between done/err and the next ack.
- ack, done and err are each one-hot or zero. done and err are never high together. At most one job is outstanding.

Test Plan:
- Single job: req=4'b0001, req_cfg[0]=32'hA5A5_0001, cfg_ready 1 cycle after cfg_write, process_done 10 cycles after start -> ack[0] at cycle 1, cfg_wdata=A5A5_0001, one start_process pulse, done[0] 1 cycle after process_done sampled, job_count=1.
- Round-robin fairness: req=4'b1111 held, each job completing -> grant order 0,1,2,3,0; ack and done pulses are one-hot; job_count=5.
- Priority rotation: after grant 2 completes, req=4'b0101 -> next grant_id=0, not 2.
- Timeout: TIMEOUT_CYCLES=16, process_done never asserted -> err[grant_id] and abort pulse after 16 WAIT cycles, return to IDLE, job_count unchanged; same behaviour with cfg_ready held low in CFG.
- Race and stale done: process_done arrives in the final timeout cycle -> done only, no err. process_done held high from the previous job -> not counted in the first WAIT cycle.
- Reset mid-WAIT: assert reset while busy=1 -> all outputs 0 immediately, no done/err/abort. After release, req=4'b0010 is granted to requester 1.

Source files
------------

// File: rtl/nn_job_scheduler.sv
// Round-robin job scheduler sitting in front of one shared dataflow pipeline.
// Accepts one job at a time from NUM_REQ requesters, pushes the winner's
// config word to the controller, pulses start_process and waits for
// process_done. Each job ends with a done or err pulse to its requester.
module nn_job_scheduler #(
  parameter int unsigned NUM_REQ        = 4,
  parameter int unsigned DATA_WIDTH     = 32,
  parameter int unsigned TIMEOUT_CYCLES = 1024,
  parameter int unsigned CNT_WIDTH      = 16
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [NUM_REQ-1:0]            req,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_cfg,
  output logic [NUM_REQ-1:0]            ack,
  output logic [NUM_REQ-1:0]            done,
  output logic [NUM_REQ-1:0]            err,
  output logic                          cfg_write,
  output logic [DATA_WIDTH-1:0]         cfg_wdata,
  input  logic                          cfg_ready,
  output logic                          start_process,
  input  logic                          process_done,
  output logic                          abort,
  output logic                          busy,
  output logic [$clog2(NUM_REQ)-1:0]    grant_id,
  output logic [CNT_WIDTH-1:0]          job_count
);

  localparam int unsigned IdW  = $clog2(NUM_REQ);
  localparam int unsigned TmrW = $clog2(TIMEOUT_CYCLES) + 1;

  localparam logic [IdW:0]      NumReqW     = (IdW+1)'(NUM_REQ);
  localparam logic [IdW-1:0]    LastGrantRst = IdW'(NUM_REQ - 1);
  localparam logic [TmrW-1:0]   TimeoutLast = TmrW'(TIMEOUT_CYCLES - 1);

  localparam logic [1:0] StIdle  = 2'd0;
  localparam logic [1:0] StCfg   = 2'd1;
  localparam logic [1:0] StStart = 2'd2;
  localparam logic [1:0] StWait  = 2'd3;

  logic [1:0]            state_q, state_d;
  logic [TmrW-1:0]       timer_q, timer_d, timer_inc;
  logic [IdW-1:0]        last_grant_q, last_grant_d;
  logic [IdW-1:0]        grant_id_q, grant_id_d;
  logic [NUM_REQ-1:0]    ack_q, ack_d;
  logic [NUM_REQ-1:0]    done_q, done_d;
  logic [NUM_REQ-1:0]    err_q, err_d;
  logic                  cfg_write_q, cfg_write_d;
  logic [DATA_WIDTH-1:0] cfg_wdata_q, cfg_wdata_d;
  logic                  start_q, start_d;
  logic                  abort_q, abort_d;
  logic                  busy_q, busy_d;
  logic [CNT_WIDTH-1:0]  job_count_q, job_count_d;

  logic                  win_found;
  logic [IdW-1:0]        win_idx;
  logic [IdW:0]          cand;
  logic [DATA_WIDTH-1:0] cfg_slice [NUM_REQ];

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_slice
    assign cfg_slice[g] = req_cfg[g*DATA_WIDTH +: DATA_WIDTH];
  end

  // Round-robin pick: first set req bit searching upward from last_grant+1.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    cand      = '0;
    for (int unsigned i = 1; i <= NUM_REQ; i++) begin
      cand = {1'b0, last_grant_q} + (IdW+1)'(i);
      if (cand >= NumReqW) cand = cand - NumReqW;
      if (!win_found && req[cand[IdW-1:0]]) begin
        win_found = 1'b1;
        win_idx   = cand[IdW-1:0];
      end
    end
  end

  // Job FSM: next state, timeout timer and all registered outputs.
  always_comb begin
    state_d      = state_q;
    timer_d      = timer_q;
    last_grant_d = last_grant_q;
    grant_id_d   = grant_id_q;
    ack_d        = '0;
    done_d       = '0;
    err_d        = '0;
    start_d      = 1'b0;
    abort_d      = 1'b0;
    cfg_write_d  = cfg_write_q;
    cfg_wdata_d  = cfg_wdata_q;
    job_count_d  = job_count_q;
    timer_inc    = (timer_q == {TmrW{1'b1}}) ? timer_q : timer_q + 1'b1;

    case (state_q)
      StIdle: begin
        if (win_found) begin
          state_d          = StCfg;
          ack_d[win_idx]   = 1'b1;
          grant_id_d       = win_idx;
          cfg_wdata_d      = cfg_slice[win_idx];
          cfg_write_d      = 1'b1;
          timer_d          = '0;
        end
      end
      StCfg: begin
        if (cfg_ready) begin
          cfg_write_d = 1'b0;
          start_d     = 1'b1;
          state_d     = StStart;
        end else if (timer_q == TimeoutLast) begin
          err_d[grant_id_q] = 1'b1;
          abort_d           = 1'b1;
          cfg_write_d       = 1'b0;
          last_grant_d      = grant_id_q;
          state_d           = StIdle;
        end else begin
          timer_d = timer_inc;
        end
      end
      StStart: begin
        timer_d = '0;
        state_d = StWait;
      end
      StWait: begin
        // timer is 0 only in the first WAIT cycle, where a stale latched
        // process_done from the previous job may still be visible.
        if ((timer_q != '0) && process_done) begin
          done_d[grant_id_q] = 1'b1;
          job_count_d        = job_count_q + 1'b1;
          last_grant_d       = grant_id_q;
          state_d            = StIdle;
        end else if (timer_q == TimeoutLast) begin
          err_d[grant_id_q] = 1'b1;
          abort_d           = 1'b1;
          cfg_write_d       = 1'b0;
          last_grant_d      = grant_id_q;
          state_d           = StIdle;
        end else begin
          timer_d = timer_inc;
        end
      end
      default: state_d = StIdle;
    endcase

    busy_d = (state_d != StIdle);
  end

  // State and output registers; reset aborts any job silently.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= StIdle;
      timer_q      <= '0;
      last_grant_q <= LastGrantRst;
      grant_id_q   <= '0;
      ack_q        <= '0;
      done_q       <= '0;
      err_q        <= '0;
      cfg_write_q  <= 1'b0;
      cfg_wdata_q  <= '0;
      start_q      <= 1'b0;
      abort_q      <= 1'b0;
      busy_q       <= 1'b0;
      job_count_q  <= '0;
    end else begin
      state_q      <= state_d;
      timer_q      <= timer_d;
      last_grant_q <= last_grant_d;
      grant_id_q   <= grant_id_d;
      ack_q        <= ack_d;
      done_q       <= done_d;
      err_q        <= err_d;
      cfg_write_q  <= cfg_write_d;
      cfg_wdata_q  <= cfg_wdata_d;
      start_q      <= start_d;
      abort_q      <= abort_d;
      busy_q       <= busy_d;
      job_count_q  <= job_count_d;
    end
  end

  assign ack           = ack_q;
  assign done          = done_q;
  assign err           = err_q;
  assign cfg_write     = cfg_write_q;
  assign cfg_wdata     = cfg_wdata_q;
  assign start_process = start_q;
  assign abort         = abort_q;
  assign busy          = busy_q;
  assign grant_id      = grant_id_q;
  assign job_count     = job_count_q;

endmodule

// File: tb/tb_nn_job_scheduler.sv
// Scoreboard bench for nn_job_scheduler: directed jobs push expected
// ack/done/err events; a negedge monitor pops and compares them.
module tb_nn_job_scheduler;

  logic         clk = 1'b0;
  logic         reset;
  logic [3:0]   req;
  logic [127:0] req_cfg;
  logic [3:0]   ack, done, err;
  logic         cfg_write;
  logic [31:0]  cfg_wdata;
  logic         cfg_ready;
  logic         start_process;
  logic         process_done;
  logic         abort;
  logic         busy;
  logic [1:0]   grant_id;
  logic [15:0]  job_count;

  always #5 clk = ~clk;

  nn_job_scheduler #(
    .NUM_REQ       (4),
    .DATA_WIDTH    (32),
    .TIMEOUT_CYCLES(16),
    .CNT_WIDTH     (16)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .req          (req),
    .req_cfg      (req_cfg),
    .ack          (ack),
    .done         (done),
    .err          (err),
    .cfg_write    (cfg_write),
    .cfg_wdata    (cfg_wdata),
    .cfg_ready    (cfg_ready),
    .start_process(start_process),
    .process_done (process_done),
    .abort        (abort),
    .busy         (busy),
    .grant_id     (grant_id),
    .job_count    (job_count)
  );

  // kind: 0 = ack, 1 = done, 2 = err
  typedef struct {
    int          kind;
    int          id;
    logic [31:0] cfg;
    int          cnt;
  } exp_t;

  exp_t        sbq[$];
  int          checks = 0;
  int          failures = 0;
  int          exp_cnt = 0;
  int          starts = 0;
  bit          start_prev = 1'b0;
  logic [31:0] cfg_tab [4];

  // Controller model knobs
  int cfg_delay = 1;
  int done_delay = 10;
  bit stale_mode = 1'b0;
  int cw = 0;
  int pc = 0;
  int clr_cnt = 0;
  bit running = 1'b0;

  task automatic chk(input string name, input bit ok, input logic [63:0] act,
                     input logic [63:0] expv);
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL %s: actual=%0h expected=%0h", name, act, expv);
    end
  endtask

  task automatic mon_event(input int kind, input logic [3:0] vec);
    exp_t        e;
    logic [3:0]  onehot;
    chk("event_expected", sbq.size() != 0, 64'(vec), 0);
    if (sbq.size() == 0) return;
    e = sbq.pop_front();
    onehot = 4'b0001 << e.id;
    chk("event_kind", kind == e.kind, 64'(kind), 64'(e.kind));
    chk("event_onehot_id", vec == onehot, 64'(vec), 64'(onehot));
    case (kind)
      0: begin
        chk("ack_cfg_write", cfg_write == 1'b1, 64'(cfg_write), 1);
        chk("ack_cfg_wdata", cfg_wdata == e.cfg, 64'(cfg_wdata), 64'(e.cfg));
        chk("ack_grant_id", int'(grant_id) == e.id, 64'(grant_id), 64'(e.id));
        chk("ack_busy", busy == 1'b1, 64'(busy), 1);
      end
      1: begin
        chk("done_job_count", int'(job_count) == e.cnt, 64'(job_count), 64'(e.cnt));
        chk("done_no_err_abort", err == 4'b0 && !abort, 64'({abort, err}), 0);
      end
      default: begin
        chk("err_job_count", int'(job_count) == e.cnt, 64'(job_count), 64'(e.cnt));
        chk("err_no_done", done == 4'b0, 64'(done), 0);
        chk("err_cfg_write_low", cfg_write == 1'b0, 64'(cfg_write), 0);
      end
    endcase
  endtask

  // Monitor: compare every DUT event against the scoreboard queue.
  always @(negedge clk) begin
    if (!reset) begin
      if (start_process) begin
        starts++;
        chk("start_one_cycle", !start_prev, 64'(start_prev), 0);
      end
      start_prev = start_process;
      if (abort || err != 4'b0)
        chk("abort_with_err", abort == (err != 4'b0), 64'(abort), 64'(err != 4'b0));
      if (ack != 4'b0)  mon_event(0, ack);
      if (done != 4'b0) mon_event(1, done);
      if (err != 4'b0)  mon_event(2, err);
    end
  end

  // Controller model: cfg_ready after cfg_delay cycles, latched process_done
  // done_delay cycles after start, cleared by start (late in stale_mode).
  initial begin
    cfg_ready    = 1'b0;
    process_done = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (reset) begin
        cw = 0; running = 1'b0; clr_cnt = 0;
        cfg_ready = 1'b0; process_done = 1'b0;
      end else begin
        if (cfg_write) begin
          cw++;
          cfg_ready = (cfg_delay >= 0) && (cw > cfg_delay);
        end else begin
          cw = 0;
          cfg_ready = 1'b0;
        end
        if (clr_cnt > 0) begin
          clr_cnt--;
          if (clr_cnt == 0) process_done = 1'b0;
        end
        if (start_process) begin
          if (stale_mode) clr_cnt = 2;
          else process_done = 1'b0;
          running = 1'b1;
          pc = 0;
        end else if (running) begin
          pc++;
          if (done_delay >= 0 && pc == done_delay) begin
            process_done = 1'b1;
            running = 1'b0;
          end
        end
      end
    end
  end

  task automatic check_all_zero(input string name);
    chk(name, {ack, done, err, cfg_write, cfg_wdata, start_process, abort, busy,
               grant_id, job_count} == '0, 64'({ack, done, err, busy, job_count}), 0);
  endtask

  task automatic do_reset();
    @(posedge clk);
    #2 reset = 1'b1;
    #1 check_all_zero("reset_outputs_zero");
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    exp_cnt = 0;
    chk("reset_no_pending_events", sbq.size() == 0, 64'(sbq.size()), 0);
  endtask

  // One job: push expected ack and outcome, wait for both with bounds.
  task automatic run_job(input int id, input int cdly, input int ddly, input int kind,
                         input logic [3:0] clr);
    exp_t e;
    int   st0;
    int   lat;
    bit   seen;
    cfg_delay = cdly;
    done_delay = ddly;
    e.kind = 0; e.id = id; e.cfg = cfg_tab[id]; e.cnt = 0;
    sbq.push_back(e);
    if (kind == 1) exp_cnt++;
    e.kind = kind; e.cnt = exp_cnt;
    sbq.push_back(e);
    st0 = starts;
    seen = 1'b0;
    lat = 0;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(posedge clk);
      #1;
      if (ack != 4'b0) begin seen = 1'b1; lat = i; end
    end
    chk("ack_seen", seen, 64'(seen), 1);
    chk("ack_latency", lat == 0, 64'(lat), 0);
    req = req & ~clr;
    seen = 1'b0;
    for (int i = 0; i < 100 && !seen; i++) begin
      @(posedge clk);
      #1;
      if (done != 4'b0 || err != 4'b0) seen = 1'b1;
    end
    chk("outcome_seen", seen, 64'(seen), 1);
    chk("idle_at_outcome", !busy && ack == 4'b0, 64'({busy, ack}), 0);
    chk("start_pulse_count", (starts - st0) == ((cdly < 0) ? 0 : 1),
        64'(starts - st0), (cdly < 0) ? 0 : 1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit seen;
    cfg_tab[0] = 32'hA5A5_0001;
    cfg_tab[1] = 32'h5A5A_0002;
    cfg_tab[2] = 32'hC3C3_0003;
    cfg_tab[3] = 32'h3C3C_0004;
    req_cfg = {cfg_tab[3], cfg_tab[2], cfg_tab[1], cfg_tab[0]};
    req = 4'b0;
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1 check_all_zero("reset_state");
    reset = 1'b0;

    // Single job
    @(posedge clk); #1;
    req = 4'b0001;
    run_job(0, 1, 10, 1, 4'b0001);

    // Fairness from a fresh reset: 0,1,2,3,0 with req held
    do_reset();
    req = 4'b1111;
    run_job(0, 0, 3, 1, 4'b0000);
    run_job(1, 1, 5, 1, 4'b0000);
    run_job(2, 2, 2, 1, 4'b0000);
    run_job(3, 3, 7, 1, 4'b0000);
    run_job(0, 1, 4, 1, 4'b1111);

    // Priority rotation: after grant 2, 0101 picks 0 then 2
    @(posedge clk); #1;
    req = 4'b0100;
    run_job(2, 1, 3, 1, 4'b0100);
    @(posedge clk); #1;
    req = 4'b0101;
    run_job(0, 1, 3, 1, 4'b0001);
    run_job(2, 1, 3, 1, 4'b0100);

    // Timeout in WAIT, then in CFG
    @(posedge clk); #1;
    req = 4'b0010;
    run_job(1, 1, -1, 2, 4'b0010);
    @(posedge clk); #1;
    req = 4'b1000;
    run_job(3, -1, 5, 2, 4'b1000);

    // process_done in the last timeout cycle: done wins
    @(posedge clk); #1;
    req = 4'b0001;
    run_job(0, 1, 16, 1, 4'b0001);

    // Stale process_done still high in first WAIT cycle must be ignored
    stale_mode = 1'b1;
    @(posedge clk); #1;
    req = 4'b0010;
    run_job(1, 1, -1, 2, 4'b0010);
    stale_mode = 1'b0;

    // Reset while busy in WAIT
    @(posedge clk); #1;
    cfg_delay = 1;
    done_delay = -1;
    req = 4'b0100;
    begin
      exp_t e;
      e.kind = 0; e.id = 2; e.cfg = cfg_tab[2]; e.cnt = 0;
      sbq.push_back(e);
    end
    seen = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(posedge clk); #1;
      if (start_process) seen = 1'b1;
    end
    chk("reset_job_started", seen, 64'(seen), 1);
    req = 4'b0;
    repeat (3) @(posedge clk);
    #1 chk("busy_before_reset", busy == 1'b1, 64'(busy), 1);
    do_reset();
    repeat (3) @(posedge clk);
    #1 chk("no_event_after_reset", sbq.size() == 0 && done == 4'b0 && err == 4'b0,
           64'(sbq.size()), 0);
    req = 4'b0010;
    run_job(1, 1, 4, 1, 4'b0010);

    repeat (5) @(posedge clk);
    #1 chk("scoreboard_drained", sbq.size() == 0, 64'(sbq.size()), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
